// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB full-speed receive controller.
package usb_rx_pkg;

  localparam int         PID_W         = 4;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'h80;

  typedef enum logic [3:0] {
    IDLE,
    SYNC,
    CHK_SYNC,
    PID,
    RCV,
    STORE,
    EOP_WAIT,
    ERR,
    ERR_WAIT
  } rx_state_t;

endpackage

// File: rtl/flex_counter.sv
// Generic up-counter with synchronous clear, enable and programmable rollover.
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  // Count up while enabled; wrap to 1 after reaching the rollover value.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      count_out <= '0;
    else if (clear)
      count_out <= '0;
    else if (count_enable) begin
      if (count_out == rollover_val)
        count_out <= NUM_CNT_BITS'(1);
      else
        count_out <= count_out + 1'b1;
    end
  end

  assign rollover_flag = (count_out == rollover_val);

endmodule

// File: rtl/usb_rx_ctrl.sv
// Receive control FSM: sync/PID qualification, per-byte FIFO strobes,
// EOP framing and sticky error reporting.
module usb_rx_ctrl
  import usb_rx_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int         MAX_BYTES = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d_edge,
  input  logic             eop,
  input  logic             shift_en,
  input  logic             bit_stuff,
  input  logic             byte_rcvd,
  input  logic [7:0]       rcv_data,
  output logic             rcving,
  output logic             w_enable,
  output logic             r_error,
  output logic [PID_W-1:0] rcv_pid,
  output logic             pkt_done
);

  // Byte count must reach MAX_BYTES + 1 to mark an overflowing packet.
  localparam int CNT_W = $clog2(MAX_BYTES + 2);

  rx_state_t        state;
  logic [2:0]       bit_cnt;
  logic [CNT_W-1:0] byte_cnt;
  logic             byte_max;
  logic             cnt_clear;
  logic             se0_sample;

  assign se0_sample = eop & shift_en;
  assign cnt_clear  = (state == IDLE) & d_edge;

  // Byte counter saturates: enable is gated once the overflow value is held.
  flex_counter #(.NUM_CNT_BITS(CNT_W)) u_byte_cnt (
    .clk          (clk),
    .n_rst        (~rst),
    .clear        (cnt_clear),
    .count_enable ((state == STORE) & ~byte_max),
    .rollover_val (CNT_W'(MAX_BYTES + 1)),
    .count_out    (byte_cnt),
    .rollover_flag(byte_max)
  );

  assign rcving   = (state != IDLE);
  assign w_enable = (state == STORE);

  // Packet sequencing FSM with its registered outputs and bit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      r_error  <= 1'b0;
      rcv_pid  <= '0;
      pkt_done <= 1'b0;
      bit_cnt  <= '0;
    end else begin
      pkt_done <= 1'b0;

      // Byte boundary clear wins over the bit increment.
      if (byte_rcvd)
        bit_cnt <= '0;
      else if ((state == RCV) && shift_en && !bit_stuff)
        bit_cnt <= bit_cnt + 3'd1;

      case (state)
        IDLE: begin
          if (d_edge) begin
            state   <= SYNC;
            r_error <= 1'b0;
            bit_cnt <= '0;
          end
        end
        SYNC: begin
          if (se0_sample) begin
            state   <= ERR;
            r_error <= 1'b1;
          end else if (byte_rcvd)
            state <= CHK_SYNC;
        end
        CHK_SYNC: begin
          if (rcv_data == SYNC_BYTE)
            state <= PID;
          else begin
            state   <= ERR;
            r_error <= 1'b1;
          end
        end
        PID: begin
          if (se0_sample) begin
            state   <= ERR;
            r_error <= 1'b1;
          end else if (byte_rcvd) begin
            if (rcv_data[7:4] == ~rcv_data[3:0]) begin
              state   <= RCV;
              rcv_pid <= rcv_data[3:0];
            end else begin
              state   <= ERR;
              r_error <= 1'b1;
            end
          end
        end
        RCV: begin
          if (se0_sample) begin
            // SE0 is only a clean end when it lands on a byte boundary.
            if (bit_cnt == 3'd0)
              state <= EOP_WAIT;
            else begin
              state   <= ERR;
              r_error <= 1'b1;
            end
          end else if (byte_rcvd)
            state <= STORE;
        end
        STORE: begin
          // The byte that pushes the count past MAX_BYTES is still written.
          if (byte_cnt == CNT_W'(MAX_BYTES)) begin
            state   <= ERR;
            r_error <= 1'b1;
          end else
            state <= RCV;
        end
        EOP_WAIT: begin
          if (d_edge) begin
            state    <= IDLE;
            pkt_done <= 1'b1;
          end
        end
        ERR: begin
          if (eop)
            state <= ERR_WAIT;
        end
        ERR_WAIT: begin
          if (d_edge)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// Directed bench for usb_rx_ctrl: default instance plus a MAX_BYTES=4 instance
// sharing the same stimulus.
module tb_usb_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       d_edge = 1'b0;
  logic       eop = 1'b0;
  logic       shift_en = 1'b0;
  logic       bit_stuff = 1'b0;
  logic       byte_rcvd = 1'b0;
  logic [7:0] rcv_data = 8'h00;

  logic       rcving, w_enable, r_error, pkt_done;
  logic [3:0] rcv_pid;
  logic       rcving4, w_enable4, r_error4, pkt_done4;
  logic [3:0] rcv_pid4;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0, we_cnt4 = 0, pd_cnt = 0, pd_cnt4 = 0;

  usb_rx_ctrl u_dut (
    .clk(clk), .rst(rst), .d_edge(d_edge), .eop(eop), .shift_en(shift_en),
    .bit_stuff(bit_stuff), .byte_rcvd(byte_rcvd), .rcv_data(rcv_data),
    .rcving(rcving), .w_enable(w_enable), .r_error(r_error),
    .rcv_pid(rcv_pid), .pkt_done(pkt_done)
  );

  usb_rx_ctrl #(.MAX_BYTES(4)) u_dut4 (
    .clk(clk), .rst(rst), .d_edge(d_edge), .eop(eop), .shift_en(shift_en),
    .bit_stuff(bit_stuff), .byte_rcvd(byte_rcvd), .rcv_data(rcv_data),
    .rcving(rcving4), .w_enable(w_enable4), .r_error(r_error4),
    .rcv_pid(rcv_pid4), .pkt_done(pkt_done4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (w_enable)  we_cnt  <= we_cnt + 1;
    if (w_enable4) we_cnt4 <= we_cnt4 + 1;
    if (pkt_done)  pd_cnt  <= pd_cnt + 1;
    if (pkt_done4) pd_cnt4 <= pd_cnt4 + 1;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic shift_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      shift_en = 1'b1; cyc(1);
      shift_en = 1'b0; cyc(3);
    end
  endtask

  // Final bit of a byte: timer rolls over on the same sample.
  task automatic last_bit(input logic [7:0] d);
    rcv_data = d; shift_en = 1'b1; byte_rcvd = 1'b1; cyc(1);
    shift_en = 1'b0; byte_rcvd = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d);
    shift_pulses(7);
    last_bit(d);
    cyc(3);
  endtask

  task automatic start_pkt;
    d_edge = 1'b1; cyc(1); d_edge = 1'b0; cyc(1);
  endtask

  task automatic eop_sample;
    eop = 1'b1; shift_en = 1'b1; cyc(1);
    shift_en = 1'b0; cyc(2);
    eop = 1'b0; cyc(1);
  endtask

  task automatic end_edge;
    d_edge = 1'b1; cyc(1); d_edge = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; cyc(2);
    checks++;
    if ({rcving, w_enable, r_error, rcv_pid, pkt_done} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 00000000", {rcving, w_enable, r_error, rcv_pid, pkt_done});
    end
    rst = 1'b0; cyc(1);
  endtask

  task automatic test_clean_packet;
    int we0, pd0;
    we0 = we_cnt; pd0 = pd_cnt;
    d_edge = 1'b1; cyc(1); d_edge = 1'b0;
    checks++;
    if (rcving !== 1'b1) begin errors++; $display("FAIL clean_rcving_rise: got %b want 1", rcving); end
    cyc(1);
    send_byte(8'h80);
    send_byte(8'hE1);
    checks++;
    if (rcv_pid !== 4'h1) begin errors++; $display("FAIL clean_pid: got %h want 1", rcv_pid); end
    shift_pulses(7);
    last_bit(8'hA5);
    checks++;
    if (w_enable !== 1'b1) begin errors++; $display("FAIL clean_wen_cycle: got %b want 1", w_enable); end
    cyc(1);
    checks++;
    if (w_enable !== 1'b0) begin errors++; $display("FAIL clean_wen_single: got %b want 0", w_enable); end
    cyc(2);
    send_byte(8'h3C);
    eop_sample;
    checks++;
    if (rcving !== 1'b1 || pkt_done !== 1'b0) begin
      errors++; $display("FAIL clean_eop_wait: rcving=%b pkt_done=%b want 1 0", rcving, pkt_done);
    end
    end_edge;
    checks++;
    if (pkt_done !== 1'b1 || rcving !== 1'b0) begin
      errors++; $display("FAIL clean_done: pkt_done=%b rcving=%b want 1 0", pkt_done, rcving);
    end
    cyc(2);
    checks++;
    if (we_cnt - we0 !== 2 || pd_cnt - pd0 !== 1 || r_error !== 1'b0) begin
      errors++; $display("FAIL clean_totals: wen=%0d done=%0d err=%b want 2 1 0", we_cnt - we0, pd_cnt - pd0, r_error);
    end
  endtask

  task automatic test_bad_sync;
    int we0;
    we0 = we_cnt;
    start_pkt;
    shift_pulses(7);
    last_bit(8'h81);
    checks++;
    if (r_error !== 1'b0) begin errors++; $display("FAIL badsync_chk_cycle: got %b want 0", r_error); end
    cyc(1);
    checks++;
    if (r_error !== 1'b1 || rcving !== 1'b1) begin
      errors++; $display("FAIL badsync_err: r_error=%b rcving=%b want 1 1", r_error, rcving);
    end
    cyc(2);
    eop = 1'b1; cyc(1); eop = 1'b0; cyc(1);
    end_edge;
    checks++;
    if (rcving !== 1'b0 || r_error !== 1'b1 || pkt_done !== 1'b0) begin
      errors++; $display("FAIL badsync_idle: rcving=%b r_error=%b pkt_done=%b want 0 1 0", rcving, r_error, pkt_done);
    end
    cyc(2);
    checks++;
    if (we_cnt - we0 !== 0) begin errors++; $display("FAIL badsync_no_wen: got %0d want 0", we_cnt - we0); end
    d_edge = 1'b1; cyc(1); d_edge = 1'b0;
    checks++;
    if (r_error !== 1'b0 || rcving !== 1'b1) begin
      errors++; $display("FAIL badsync_restart: r_error=%b rcving=%b want 0 1", r_error, rcving);
    end
    cyc(1);
  endtask

  // Continues the packet started at the end of test_bad_sync.
  task automatic test_bad_pid;
    int we0;
    we0 = we_cnt;
    send_byte(8'h80);
    send_byte(8'hE2);
    checks++;
    if (r_error !== 1'b1 || rcv_pid !== 4'h1 || we_cnt - we0 !== 0) begin
      errors++; $display("FAIL badpid: r_error=%b pid=%h wen=%0d want 1 1 0", r_error, rcv_pid, we_cnt - we0);
    end
    eop = 1'b1; cyc(1); eop = 1'b0; cyc(1);
    end_edge; cyc(2);
  endtask

  task automatic test_eop_midbyte;
    int pd0;
    pd0 = pd_cnt;
    start_pkt;
    send_byte(8'h80);
    send_byte(8'hE1);
    shift_pulses(3);
    eop = 1'b1; shift_en = 1'b1; cyc(1); shift_en = 1'b0;
    checks++;
    if (r_error !== 1'b1) begin errors++; $display("FAIL midbyte_err: got %b want 1", r_error); end
    cyc(2); eop = 1'b0; cyc(1);
    end_edge; cyc(2);
    checks++;
    if (pd_cnt - pd0 !== 0 || rcving !== 1'b0 || r_error !== 1'b1) begin
      errors++; $display("FAIL midbyte_end: done=%0d rcving=%b r_error=%b want 0 0 1", pd_cnt - pd0, rcving, r_error);
    end
  endtask

  // A stuffed sample before SE0 does not advance the bit count.
  task automatic test_stuff_eop;
    int we0, pd0;
    we0 = we_cnt; pd0 = pd_cnt;
    start_pkt;
    send_byte(8'h80);
    send_byte(8'hE1);
    send_byte(8'h55);
    bit_stuff = 1'b1; shift_en = 1'b1; cyc(1);
    shift_en = 1'b0; bit_stuff = 1'b0; cyc(3);
    eop_sample;
    end_edge; cyc(2);
    checks++;
    if (we_cnt - we0 !== 1 || pd_cnt - pd0 !== 1 || r_error !== 1'b0) begin
      errors++; $display("FAIL stuff_eop: wen=%0d done=%0d err=%b want 1 1 0", we_cnt - we0, pd_cnt - pd0, r_error);
    end
  endtask

  task automatic test_overflow;
    int we0, pd0, pd40;
    we0 = we_cnt4; pd0 = pd_cnt; pd40 = pd_cnt4;
    start_pkt;
    send_byte(8'h80);
    send_byte(8'h2D);
    for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i));
    checks++;
    if (we_cnt4 - we0 !== 4 || r_error4 !== 1'b0 || rcv_pid4 !== 4'hD) begin
      errors++; $display("FAIL ovf_four: wen=%0d err=%b pid=%h want 4 0 d", we_cnt4 - we0, r_error4, rcv_pid4);
    end
    shift_pulses(7);
    last_bit(8'h99);
    checks++;
    if (w_enable4 !== 1'b1 || r_error4 !== 1'b0) begin
      errors++; $display("FAIL ovf_fifth_wen: wen=%b err=%b want 1 0", w_enable4, r_error4);
    end
    cyc(1);
    checks++;
    if (r_error4 !== 1'b1 || w_enable4 !== 1'b0 || r_error !== 1'b0) begin
      errors++; $display("FAIL ovf_flag: err4=%b wen4=%b err64=%b want 1 0 0", r_error4, w_enable4, r_error);
    end
    cyc(2);
    eop_sample;
    end_edge; cyc(2);
    checks++;
    if (we_cnt4 - we0 !== 5 || pd_cnt4 - pd40 !== 0 || pd_cnt - pd0 !== 1 || r_error4 !== 1'b1 || rcving4 !== 1'b0) begin
      errors++; $display("FAIL ovf_end: wen4=%0d done4=%0d done64=%0d err4=%b rcving4=%b want 5 0 1 1 0",
                         we_cnt4 - we0, pd_cnt4 - pd40, pd_cnt - pd0, r_error4, rcving4);
    end
  endtask

  task automatic test_reset_mid;
    int we0, pd0;
    start_pkt;
    send_byte(8'h80);
    send_byte(8'hE1);
    shift_pulses(4);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({rcving, w_enable, r_error, rcv_pid, pkt_done} !== 8'h00) begin
      errors++; $display("FAIL midrst_outputs: got %b want 00000000", {rcving, w_enable, r_error, rcv_pid, pkt_done});
    end
    cyc(2); rst = 1'b0;
    we0 = we_cnt; pd0 = pd_cnt;
    shift_pulses(3);
    last_bit(8'h42);
    cyc(3);
    checks++;
    if (we_cnt - we0 !== 0 || pd_cnt - pd0 !== 0 || rcving !== 1'b0) begin
      errors++; $display("FAIL midrst_quiet: wen=%0d done=%0d rcving=%b want 0 0 0", we_cnt - we0, pd_cnt - pd0, rcving);
    end
    start_pkt;
    send_byte(8'h80);
    send_byte(8'hD2);
    send_byte(8'h77);
    eop_sample;
    end_edge; cyc(2);
    checks++;
    if (rcv_pid !== 4'h2 || we_cnt - we0 !== 1 || pd_cnt - pd0 !== 1 || r_error !== 1'b0) begin
      errors++; $display("FAIL midrst_recover: pid=%h wen=%0d done=%0d err=%b want 2 1 1 0",
                         rcv_pid, we_cnt - we0, pd_cnt - pd0, r_error);
    end
  endtask

  initial begin
    cyc(1);
    test_reset;
    test_clean_packet;
    test_bad_sync;
    test_bad_pid;
    test_eop_midbyte;
    test_stuff_eop;
    test_overflow;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
